// File: rtl/bldc_rate_pkg.sv
// Shared definitions for the BLDC rate path (pulse generator and window counter).
// Both blocks derive their sample period here so their boundaries line up.
package bldc_rate_pkg;

  typedef logic [31:0] rate_t;

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_PENDING = 1'b1
  } rate_state_e;

  function automatic int unsigned calc_sample_period(input int unsigned clk_hz,
                                                     input int unsigned time_ms);
    return clk_hz / 1000 * time_ms;
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/sample_period_timer.sv
// Free-running sample-period counter; boundary marks the last cycle of each period.
module sample_period_timer
  import bldc_rate_pkg::*;
#(
  parameter int unsigned sample_period = 100
) (
  input  logic sys_clk,
  input  logic reset,
  output logic boundary
);

  localparam int unsigned cnt_w = calc_cnt_width(sample_period);
  localparam logic [cnt_w-1:0] last = cnt_w'(sample_period - 1);

  logic [cnt_w-1:0] count;

  always_ff @(posedge sys_clk) begin
    if (reset)              count <= '0;
    else if (count == last) count <= '0;
    else                    count <= count + cnt_w'(1);
  end

  assign boundary = (count == last);

endmodule

// File: rtl/pulse_rate_generator.sv
// Evenly spaced single-cycle pulses at a programmed events/s rate; new rates
// are taken by valid/ready and only applied on sample-period boundaries.
module pulse_rate_generator
  import bldc_rate_pkg::*;
#(
  parameter int unsigned clk_freq_hz        = 27_000_000,
  parameter int unsigned max_possible_value = 4000,
  parameter int unsigned sample_time_ms     = 10,
  parameter int unsigned rate_width         = $clog2(max_possible_value + 1)
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [rate_width-1:0] rate_in,
  input  logic                  rate_valid,
  output logic                  rate_ready,
  input  logic                  enable,
  output logic                  pulse,
  output logic [rate_width-1:0] active_rate,
  output logic                  boundary,
  output logic                  clamped
);

  localparam int unsigned sample_period = calc_sample_period(clk_freq_hz, sample_time_ms);
  localparam int unsigned acc_w         = $clog2(clk_freq_hz + max_possible_value);
  localparam logic [acc_w-1:0]      modulus  = acc_w'(clk_freq_hz);
  localparam logic [rate_width-1:0] rate_max = rate_width'(max_possible_value);

  generate
    if (max_possible_value > clk_freq_hz) begin : g_bad_max
      $error("max_possible_value must not exceed clk_freq_hz");
    end
  endgenerate

  sample_period_timer #(.sample_period(sample_period)) u_timer (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .boundary (boundary)
  );

  rate_state_e             state, state_nxt;
  logic [rate_width-1:0]   pending;
  logic [acc_w-1:0]        acc, sum;
  logic                    xfer, apply, over;

  assign rate_ready = (state == ST_READY);
  assign xfer       = rate_valid && rate_ready;
  assign apply      = boundary && (state == ST_PENDING);
  assign over       = rate_in > rate_max;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_READY:   if (xfer)     state_nxt = ST_PENDING;
      ST_PENDING: if (boundary) state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) state <= ST_READY;
    else       state <= state_nxt;
  end

  // acc stays in [0, clk_freq_hz); it is never cleared on a rate change so
  // the pulse phase carries straight across the switch.
  assign sum = acc + acc_w'(active_rate);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      acc         <= '0;
      pulse       <= 1'b0;
      pending     <= '0;
      active_rate <= '0;
      clamped     <= 1'b0;
    end else begin
      if (enable) begin
        if (sum >= modulus) begin
          acc   <= sum - modulus;
          pulse <= 1'b1;
        end else begin
          acc   <= sum;
          pulse <= 1'b0;
        end
      end else begin
        pulse <= 1'b0;
      end
      if (xfer) begin
        pending <= over ? rate_max : rate_in;
        if (over) clamped <= 1'b1;
      end
      if (apply) active_rate <= pending;
    end
  end

endmodule

// File: tb/tb_pulse_rate_generator.sv
// Randomized bench for pulse_rate_generator against an ideal-phase reference model.
module tb_pulse_rate_generator;

  localparam int F   = 10_000;
  localparam int MAX = 4000;
  localparam int RW  = 13;
  localparam int SP  = 100;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] rate_in = '0;
  logic          rate_valid = 1'b0;
  logic          enable = 1'b1;
  logic          rate_ready, pulse, boundary, clamped;
  logic [RW-1:0] active_rate;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  pulse_rate_generator #(
    .clk_freq_hz        (F),
    .max_possible_value (MAX),
    .sample_time_ms     (10),
    .rate_width         (RW)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .rate_in     (rate_in),
    .rate_valid  (rate_valid),
    .rate_ready  (rate_ready),
    .enable      (enable),
    .pulse       (pulse),
    .active_rate (active_rate),
    .boundary    (boundary),
    .clamped     (clamped)
  );

  // Reference: total phase as an unbounded integer; a pulse is due whenever
  // floor(phase / F) advances. Rate updates land on every SP-th cycle.
  int     m_cyc = 0;
  longint m_phase = 0;
  int     m_active = 0, m_pend = 0;
  bit     m_has_pend = 0, m_clamped = 0, m_pulse = 0;
  logic   m_boundary;
  assign m_boundary = (m_cyc % SP) == SP - 1;

  always @(posedge sys_clk) begin
    if (reset) begin
      m_cyc <= 0; m_phase <= 0; m_active <= 0; m_pend <= 0;
      m_has_pend <= 0; m_clamped <= 0; m_pulse <= 0;
    end else begin
      if (enable) m_phase <= m_phase + m_active;
      m_pulse <= enable && ((m_phase + m_active) / F != m_phase / F);
      if (m_has_pend && m_boundary) begin
        m_active   <= m_pend;
        m_has_pend <= 0;
      end else if (rate_valid && !m_has_pend) begin
        m_pend     <= (int'(rate_in) > MAX) ? MAX : int'(rate_in);
        m_has_pend <= 1;
        if (int'(rate_in) > MAX) m_clamped <= 1;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  logic [RW+3:0] obs, expv;
  assign obs  = {pulse, boundary, active_rate, rate_ready, clamped};
  assign expv = {m_pulse, m_boundary, RW'(m_active), !m_has_pend, m_clamped};

  task automatic test_reset();
    reset = 1'b1; rate_valid = 1'b0; enable = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({pulse, boundary, active_rate, rate_ready, clamped} !== {2'b00, {RW{1'b0}}, 2'b10}) begin
      n_fail++;
      $display("FAIL reset_values got=%h want=%h", obs, {2'b00, {RW{1'b0}}, 2'b10});
    end
    reset = 1'b0;
  endtask

  task automatic test_rate(input int r, input int want_active, input int want_per, input int start_at);
    bit hist[0:399];
    int c_apply = -1;
    int cnt;
    for (int c = 0; c < 400; c++) begin
      rate_valid = (c == start_at) || (rate_valid && rate_ready);
      rate_in    = RW'(r);
      @(negedge sys_clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL lockstep_rate%0d t=%0t got=%h want=%h", r, $time, obs, expv);
      end
      hist[c] = pulse;
      if (c_apply < 0 && c > start_at && !m_has_pend) c_apply = c;
    end
    rate_valid = 1'b0;
    n_checks++;
    if (c_apply < 0 || c_apply - start_at < 1 || c_apply - start_at > SP + 1) begin
      n_fail++;
      $display("FAIL apply_latency_rate%0d got=%0d want=1..%0d", r, c_apply - start_at, SP + 1);
      return;
    end
    n_checks++;
    if (int'(active_rate) !== want_active) begin
      n_fail++;
      $display("FAIL active_rate_%0d got=%0d want=%0d", r, active_rate, want_active);
    end
    if (r > MAX) begin
      n_checks++;
      if (clamped !== 1'b1) begin
        n_fail++;
        $display("FAIL clamped_flag got=%b want=1", clamped);
      end
    end
    cnt = 0;
    for (int i = c_apply + 1; i < c_apply + 1 + SP; i++) cnt += int'(hist[i]);
    n_checks++;
    if (cnt !== want_per) begin
      n_fail++;
      $display("FAIL pulses_per_period_%0d got=%0d want=%0d", r, cnt, want_per);
    end
    for (int s = c_apply + 1; s < c_apply + 191; s++) begin
      cnt = 0;
      for (int i = s; i < s + 10; i++) cnt += int'(hist[i]);
      n_checks++;
      if (cnt !== want_per / 10) begin
        n_fail++;
        $display("FAIL window10_rate%0d at=%0d got=%0d want=%0d", r, s, cnt, want_per / 10);
      end
    end
  endtask

  task automatic test_boundary_xfer();
    int r = int'($urandom_range(1, MAX));
    int low = 0, applied = -1;
    bit found = 0;
    rate_valid = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge sys_clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL lockstep_bwait t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (m_boundary && !m_has_pend) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL boundary_wait got=timeout want=boundary");
      return;
    end
    rate_valid = 1'b1; rate_in = RW'(r);
    for (int k = 0; k < 150; k++) begin
      @(negedge sys_clk);
      rate_valid = 1'b0;
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL lockstep_bxfer t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (!rate_ready) low++;
      if (applied < 0 && rate_ready) begin
        applied = k;
        n_checks++;
        if (int'(active_rate) !== r) begin
          n_fail++;
          $display("FAIL bxfer_active got=%0d want=%0d", active_rate, r);
        end
      end
    end
    n_checks++;
    if (low !== SP || applied !== SP) begin
      n_fail++;
      $display("FAIL bxfer_latency got low=%0d applied=%0d want %0d/%0d", low, applied, SP, SP);
    end
  endtask

  task automatic test_enable_gap();
    int gap_pulses = 0, en_seen = 0, tot = 0;
    int gap_start = int'($urandom_range(20, 60));
    for (int k = 0; k < 220; k++) begin
      enable = !(k >= gap_start && k < gap_start + 37);
      @(negedge sys_clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL lockstep_enable t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (!enable && pulse) gap_pulses++;
      if (enable && k >= 10 && en_seen < 100) begin
        en_seen++;
        tot += int'(pulse);
      end
    end
    enable = 1'b1;
    n_checks++;
    if (gap_pulses !== 0) begin
      n_fail++;
      $display("FAIL enable_gap_pulses got=%0d want=0", gap_pulses);
    end
    n_checks++;
    if (tot !== 10) begin
      n_fail++;
      $display("FAIL enabled_total got=%0d want=10", tot);
    end
  endtask

  task automatic test_reset_pending();
    int stray = 0;
    rate_valid = 1'b1; rate_in = RW'($urandom_range(500, MAX));
    @(negedge sys_clk);
    rate_valid = 1'b0;
    n_checks++;
    if (rate_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_ready got=%b want=0", rate_ready);
    end
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    n_checks++;
    if ({active_rate, rate_ready, clamped, pulse} !== {{RW{1'b0}}, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_pending got=%h want=%h", {active_rate, rate_ready, clamped, pulse},
               {{RW{1'b0}}, 3'b100});
    end
    for (int k = 0; k < 250; k++) begin
      @(negedge sys_clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL lockstep_rstpend t=%0t got=%h want=%h", $time, obs, expv);
      end
      if (pulse || active_rate != '0) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL post_reset_activity got=%0d want=0", stray);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rate_valid = ($urandom_range(0, 3) == 0);
      rate_in    = RW'($urandom_range(0, 5500));
      enable     = ($urandom_range(0, 9) != 0);
      reset      = ($urandom_range(0, 999) == 0);
      @(negedge sys_clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL lockstep_random t=%0t got=%h want=%h", $time, obs, expv);
      end
    end
    reset = 1'b0; rate_valid = 1'b0; enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rate(1000, 1000, 10, 4);
    test_rate(3000, 3000, 30, 2);
    test_rate(5000, MAX, 40, 7);
    test_boundary_xfer();
    test_rate(1000, 1000, 10, 3);
    test_enable_gap();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_rate_generator.md
# pulse_rate_generator

Generates a train of single-cycle pulses at a programmed rate in events per second, spread as evenly as integer arithmetic allows across `sys_clk` cycles. It is the source-side counterpart of the sliding-window event counter in the BLDC speed path. It drives synthetic commutation/tach events into that counter for self-test and open-loop ramp-up. New rates are accepted through a valid/ready handshake and applied only on sample-period boundaries, so a downstream windowed counter sees clean windows.

## Interface
- `clk_freq_hz`, 27_000_000, `sys_clk` frequency; also the accumulator modulus, one second of ticks.
- `max_possible_value`, 4000, highest rate accepted, in events/s. Elaboration error if > `clk_freq_hz`.
- `sample_time_ms`, 10, period between rate-update boundaries.
- `rate_width`, `$clog2(max_possible_value + 1)`, width of rate ports.

Ports:
- `sys_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `rate_in`  in  `rate_width`  requested rate, events/s.
- `rate_valid`  in  1  `rate_in` is offered.
- `rate_ready`  out  1  a new rate can be accepted.
- `enable`  in  1  low freezes the phase accumulator and suppresses pulses.
- `pulse`  out  1  one-cycle event strobe, registered.
- `active_rate`  out  `rate_width`  rate currently being generated.
- `boundary`  out  1  one-cycle strobe on the last cycle of each sample period.
- `clamped`  out  1  sticky; set when an accepted `rate_in` exceeded `max_possible_value`.

## Operation
- Sample period is `sample_period = clk_freq_hz/1000*sample_time_ms` cycles.
- The period counter runs freely from reset, 0..`sample_period`-1, ignoring `enable`. `boundary` is high while the count equals `sample_period`-1.
- Phase accumulator `acc` lies in [0, `clk_freq_hz`). Its width is `$clog2(clk_freq_hz + max_possible_value)`.
- Each cycle with `enable`=1: `sum = acc + active_rate`.
  - If `sum >= clk_freq_hz`: `acc <= sum - clk_freq_hz` and `pulse <= 1`.
  - Otherwise: `acc <= sum` and `pulse <= 0`.
- With `enable`=0: `acc` holds and `pulse <= 0`.
- Over any `clk_freq_hz` consecutive enabled cycles, the pulse count equals `active_rate` exactly. Over any window of N enabled cycles it is within ±1 of `N*active_rate/clk_freq_hz`.
- Handshake:
  - A transfer occurs when `rate_valid && rate_ready`.
  - The transferred value is clamped to `max_possible_value`; `clamped` is set if clamping occurred.
  - The value goes into a pending register and `rate_ready` drops the following cycle.
- Apply:
  - On a `boundary` cycle with the pending flag set, `active_rate <= pending` and the pending flag clears.
  - `rate_ready` is high again on the next cycle.
  - `acc` is not reset on rate change, which keeps phase continuous.
- States:
  - READY: no pending rate.
  - PENDING: waiting for a boundary.
  - Transitions: READY→PENDING on transfer; PENDING→READY on `boundary`.
  - A transfer in the same cycle as a `boundary` enters PENDING and is applied at the *next* boundary.
- `active_rate` = 0 produces no pulses and `acc` holds its value.
- `clamped` clears only on `reset`.

## Timing
- Reset values: `pulse`=0, `boundary`=0, `active_rate`=0, `rate_ready`=1, `clamped`=0. Internally, `acc`=0, period count=0, pending flag=0.
- Reset asserted mid-operation clears everything on that edge. A pending rate is discarded.
- `pulse` appears one cycle after the cycle whose `sum` crossed the modulus.
- From reset with rate R applied, the first pulse is high on the cycle after `acc` first reaches ≥ `clk_freq_hz`. That is ceil(`clk_freq_hz`/R) enabled cycles after the rate took effect.
- `active_rate` changes the cycle after a `boundary`. The new rate first affects `acc` on that cycle.
- Transfer-to-apply latency ranges from 1 to `sample_period` cycles.
- `rate_valid` may be held. A single transfer occurs and the source must drop or change the request after the handshake.

## Structure
- Shared package `bldc_rate_pkg` holds `rate_t` and `sample_period` derivation helpers. These are common with the window counter so both agree on boundaries.
- One sub-module, `sample_period_timer`: the free-running period counter producing `boundary`. It is reusable by the window counter, so both align when reset together.

## Test plan
Bench parameters: `clk_freq_hz`=10_000, `sample_time_ms`=10, giving `sample_period`=100.

- Write rate 1000 at cycle 5 → applied after the first `boundary`. Pulses then occur exactly every 10 cycles, 10 per period.
- Rate 3000 → 30 pulses per 100-cycle period; every 10-cycle window holds 3 pulses.
- Rate 5000 → `active_rate`=4000, `clamped`=1, and 40 pulses per period.
- Transfer on a `boundary` cycle → not applied at that boundary; applied 100 cycles later. `rate_ready` is low in between.
- Rate 1000 with `enable` low for 37 cycles → no pulses. Afterwards the phase resumes and the total across enabled cycles stays exact.
- `reset` pulsed while PENDING → `active_rate`=0, `rate_ready`=1, and no pulses until a new rate is applied.
